pipelined_addsub: RTL
=====================

// Module: pipelined_addsub
// PURPOSE
//  K-bit add/subtract unit built as a pipelined ripple-carry chain. The carry ripples through
//  STAGES segments, and a register sits between segments. Throughput is one operation per cycle.
//  Valid/ready handshake on the input and output sides. Sits between operand producers and
//  accumulators in the datapath. Successor to the single-cycle generic ripple adder.
// PARAMETERS
//  K       8  operand/result width in bits; K >= 1
//  STAGES  2  pipeline segments; 1 <= STAGES <= K, K % STAGES == 0; segment width W = K/STAGES
// PORTS
//  clk        in   1  clock, rising edge
//  rst_n      in   1  asynchronous reset, active low
//  in_valid   in   1  operand beat valid
//  in_ready   out  1  unit accepts beat this cycle
//  a          in   K  operand A, unsigned or two's complement
//  b          in   K  operand B
//  sub        in   1  0: a+b; 1: a-b
//  out_valid  out  1  result beat valid
//  out_ready  in   1  consumer accepts result
//  sum        out  K  result, modulo 2^K
//  cout       out  1  carry out of MSB (for sub: 1 = no borrow)
//  overflow   out  1  signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valid bits = 0. out_valid=0, sum=0, cout=0, overflow=0.
//    Data registers are cleared to 0.
//  - Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational).
//    All stage registers load only when adv=1; otherwise every stage holds.
//  - Accept: in_valid && in_ready. On accept, stage 0 captures:
//    - b_eff = sub ? ~b : b, and cin0 = sub.
//    - Sum and carry of segment 0, bits [W-1:0].
//    - Skewed upper slices of a and b_eff.
//  - Stage s (1..STAGES-1):
//    - Adds slice [s*W +: W] of the skewed operands plus the registered carry from stage s-1.
//    - Forwards lower result slices and the remaining upper operand slices.
//  - Each stage register carries a valid bit. A bubble (no accept) propagates as valid=0.
//  - Latency: STAGES cycles from accept to out_valid with no stall. STAGES=1 gives a registered output.
//  - Output hold: while out_valid && !out_ready, sum/cout/overflow are stable and in_ready=0.
//  - Order: strictly FIFO. No beat is dropped or duplicated across stalls.
//  - overflow uses the carry into bit K-1 and the carry out of bit K-1. Both come from the last stage.
//  - Simultaneous output handshake and accept: both complete in the same cycle (full throughput).
//  - Reset mid-operation flushes all in-flight beats. There is no output for them after rst_n rises.
//  - sub may change every beat; each beat uses its own sub value.
//  - out_valid changes only on clk or reset; no combinational path from in_valid to out_valid.
// STRUCTURE
//  - Shared package adder_pkg holds:
//    - localparam MODE_ADD=1'b0, MODE_SUB=1'b1.
//    - Function seg_width(K,STAGES).
//  - One sub-module: adder_segment #(W).
//    - Combinational W-bit ripple of one-bit full-adder cells.
//    - Ports: a, b, cin -> sum, cout, and c_msb_in (carry into the segment MSB, used for overflow).
//    - Instantiated STAGES times in a generate loop.
//  - Top level holds the stage registers, skew registers, valid bits and handshake logic.
//  - Parameter legality is checked at elaboration. An illegal K/STAGES combination is an error.
// TESTING (K=8, STAGES=2 unless noted; bench uses a cycle-accurate reference model)
//  1. Reset, then idle: out_valid=0, sum=8'h00, cout=0, overflow=0, in_ready=1.
//  2. add 8'hFF+8'h01, out_ready=1: 2 cycles later sum=8'h00, cout=1, overflow=0.
//  3. add 8'h7F+8'h01: sum=8'h80, cout=0, overflow=1.
//     sub 8'h80-8'h01: sum=8'h7F, cout=1, overflow=1.
//     sub 8'h00-8'h01: sum=8'hFF, cout=0, overflow=0.
//  4. Back-to-back beats 1+2, 3+4, 5+6, with out_ready=0 for 3 cycles after the first result:
//     in_ready=0 while stalled, 8'h03 held stable, then 8'h07 and 8'h0B follow in order; no loss.
//  5. rst_n pulsed low with 2 beats in flight: out_valid=0 immediately.
//     After release, no result appears until a new accept.
//  6. 10k random beats with random sub/in_valid/out_ready, for STAGES=1,2,4,8:
//     every result matches the model in value and order.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: operation encoding
// and the segment-width helper used to split the carry chain.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Guarded against stages=0 so the legality check can report it cleanly.
  function automatic int seg_width(input int k, input int stages);
    return (stages > 0) ? (k / stages) : 1;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational W-bit ripple-carry segment built from one-bit full-adder cells.
// Also exposes the carry into its MSB so the top segment can derive signed overflow.
module adder_segment #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout     = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// K-bit add/subtract unit: the carry chain is cut into STAGES registered segments,
// with a single global advance so the whole pipe stalls together under backpressure.
module pipelined_addsub
  import adder_pkg::*;
#(
  parameter int K      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int W = seg_width(K, STAGES);

  if (K < 1 || STAGES < 1 || STAGES > K || (K % STAGES) != 0) begin : g_param_check
    $error("pipelined_addsub: illegal K/STAGES combination");
  end

  logic         adv;
  logic [K-1:0] b_eff;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = (sub == MODE_SUB) ? ~b : b;

  // Stage s adds slice s and keeps the result bits produced so far plus the
  // operand slices that later stages still need (the skew registers).
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [W-1:0]         op_a;
    logic [W-1:0]         op_b;
    logic [W-1:0]         seg_sum;
    logic                 c_in;
    logic                 seg_cout;
    logic                 valid_in;
    logic [(s+1)*W-1:0]   sum_next;
    logic [(s+1)*W-1:0]   sum_q;
    logic                 carry_q;
    logic                 vld_q;

    if (s == 0) begin : g_head
      assign op_a     = a[W-1:0];
      assign op_b     = b_eff[W-1:0];
      assign c_in     = (sub == MODE_SUB);
      assign valid_in = in_valid;
      assign sum_next = seg_sum;
    end else begin : g_body
      assign op_a     = g_stage[s-1].g_fwd.a_rem[W-1:0];
      assign op_b     = g_stage[s-1].g_fwd.b_rem[W-1:0];
      assign c_in     = g_stage[s-1].carry_q;
      assign valid_in = g_stage[s-1].vld_q;
      assign sum_next = {seg_sum, g_stage[s-1].sum_q};
    end

    // Only the last segment's MSB carry matters; it feeds the overflow flag.
    if (s == STAGES-1) begin : g_tail
      logic seg_cmsb;
      logic cmsb_q;

      adder_segment #(.W(W)) u_seg (
        .a        (op_a),
        .b        (op_b),
        .cin      (c_in),
        .sum      (seg_sum),
        .cout     (seg_cout),
        .c_msb_in (seg_cmsb)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cmsb_q <= 1'b0;
        end else if (adv) begin
          cmsb_q <= seg_cmsb;
        end
      end
    end else begin : g_mid
      adder_segment #(.W(W)) u_seg (
        .a        (op_a),
        .b        (op_b),
        .cin      (c_in),
        .sum      (seg_sum),
        .cout     (seg_cout),
        .c_msb_in ()
      );
    end

    if (s < STAGES-1) begin : g_fwd
      logic [K-(s+1)*W-1:0] a_src;
      logic [K-(s+1)*W-1:0] b_src;
      logic [K-(s+1)*W-1:0] a_rem;
      logic [K-(s+1)*W-1:0] b_rem;

      if (s == 0) begin : g_src_in
        assign a_src = a[K-1:W];
        assign b_src = b_eff[K-1:W];
      end else begin : g_src_prev
        assign a_src = g_stage[s-1].g_fwd.a_rem[K-s*W-1:W];
        assign b_src = g_stage[s-1].g_fwd.b_rem[K-s*W-1:W];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem <= '0;
          b_rem <= '0;
        end else if (adv) begin
          a_rem <= a_src;
          b_rem <= b_src;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q   <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        vld_q   <= valid_in;
        carry_q <= seg_cout;
        sum_q   <= sum_next;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].carry_q;
  assign overflow  = g_stage[STAGES-1].carry_q ^ g_stage[STAGES-1].g_tail.cmsb_q;

endmodule
